gen12_multilane_scrambler: RTL and testbench
============================================

// Module: gen12_multilane_scrambler
// PURPOSE
//  Parametrised Gen1/Gen2 (8b/10b) PCIe data scrambler for NUM_LANES lanes, BYTES_PER_LANE symbols per lane per beat.
//  Each lane has its own LFSR: x^16+x^5+x^4+x^3+1, seed 16'hFFFF. COM re-seeds the LFSR; SKP freezes it.
//  Sits between the TX data mux and the 8b/10b encoders. Valid/ready streaming with one registered output stage.
// PARAMETERS
//  NUM_LANES       4   lanes, each with an independent LFSR
//  BYTES_PER_LANE  4   symbols per lane per beat (1,2,4); byte 0 is earliest in time
//  LEN_W           2   width of len fields = max(1,$clog2(BYTES_PER_LANE))
// PORTS
//  clk_i                input   1                       clock
//  rst_i                input   1                       asynchronous reset, active-high
//  in_valid_i           input   1                       input beat valid
//  in_ready_o           output  1                       input beat accepted when valid&&ready
//  in_data_i            input   NUM_LANES*BYTES_PER_LANE*8  lane l byte b at bit (l*BYTES_PER_LANE+b)*8
//  in_datak_i           input   NUM_LANES*BYTES_PER_LANE    1 = K symbol
//  in_ts_i              input   NUM_LANES*BYTES_PER_LANE    1 = TS1/TS2 data symbol (not scrambled)
//  in_len_i             input   LEN_W                   valid bytes per lane minus 1, shared by all lanes
//  scramble_enable_i    input   1                       0 = bypass scrambling (LFSR still tracks)
//  out_valid_o          output  1                       output beat valid
//  out_ready_i          input   1                       downstream accepts
//  out_data_o           output  NUM_LANES*BYTES_PER_LANE*8  scrambled data, same layout as input
//  out_datak_o          output  NUM_LANES*BYTES_PER_LANE    registered copy of in_datak_i
//  out_len_o            output  LEN_W                   registered copy of in_len_i
// BEHAVIOUR
//  - Reset: every lane LFSR = 16'hFFFF; out_valid_o=0; out_data_o, out_datak_o, out_len_o = 0.
//  - Handshake: in_ready_o = !out_valid_o || out_ready_i. Output register loads on accept; latency 1 cycle.
//  - Output holds stable while out_valid_o && !out_ready_i. out_valid_o clears when consumed with no new accept.
//  - LFSR state changes only on an accepted beat. Stalls and idle cycles leave it unchanged.
//  - Byte step, data bits LSB first, for i=0..7:
//      o[i] = d[i] ^ lfsr[15]
//      lfsr = {lfsr[14:0],1'b0} ^ (lfsr[15] ? 16'h0039 : 0)
//  - Per byte, in lane order b=0..in_len_i; bytes b>in_len_i output 8'h00 and do not advance the LFSR:
//      K && data==8'hBC (COM): output unscrambled; LFSR for next byte = 16'hFFFF.
//      K && data==8'h1C (SKP): output unscrambled; LFSR not advanced.
//      other K, or in_ts_i=1: output unscrambled; LFSR advances 8 steps.
//      D and !ts: output scrambled when scramble_enable_i=1, else raw; LFSR advances 8 steps.
//  - Multiple COMs in one beat: each re-seeds; the last governs. COM at the final valid byte → next beat starts at FFFF.
//  - in_len_i > BYTES_PER_LANE-1: clamp to BYTES_PER_LANE-1.
//  - Reset mid-beat: output beat dropped, out_valid_o=0, all LFSRs reseeded.
// CONFIGURATION
//  Macro SCRAMBLER_LFSR_OBS_EN.
//  - Defined: adds output lfsr_state_o [NUM_LANES*16], lane l at [l*16+:16]. It is the registered LFSR state
//    (value to be used for the next accepted byte 0). Reset value all 16'hFFFF.
//  - Undefined: the port is absent; behaviour is otherwise identical.
// STRUCTURE
//  - Package gen12_scrambler_pkg:
//      K_COM=8'hBC, K_SKP=8'h1C, LFSR_SEED=16'hFFFF, LFSR_TAPS=16'h0039
//      function lfsr_step8(lfsr, data) → {next_lfsr, scrambled_byte}
//  - Sub-module gen12_lane_scrambler: one lane, combinational BYTES_PER_LANE-deep byte chain, and a 16-bit LFSR register
//    with load enable. Top generates NUM_LANES instances plus the shared output register and handshake.
// TESTING
//  1 Reset, then 4 lanes each get COM in byte0, D 8'h00 in bytes1-3, len=3, enable=1 → each lane's out bytes1-3 = FF,17,C0.
//  2 Next beat: all D 8'h00, len=3 → 14,B2,E7,02 on every lane; lfsr_state_o identical across lanes.
//  3 Lane0 byte1 = SKP, other lanes D, same input data → lane0 keystream lags the other lanes by exactly one byte.
//  4 out_ready_i=0 for 3 cycles with in_valid_i=1 → in_ready_o=0, out_data_o stable, LFSR unchanged; release → stream continues seamlessly.
//  5 len=0 for 4 beats vs len=3 for 1 beat, same bytes → identical keystream; out bytes 1-3 = 00 in len=0 beats.
//  6 scramble_enable_i=0 and ts=1 beats → data passes raw, but a following enabled beat uses the LFSR advanced through them.

Source files
------------

// File: rtl/gen12_scrambler_pkg.sv
// ---------------------------------------------------------------------------
// gen12_scrambler_pkg
// Shared constants and the byte-wide LFSR step for the Gen1/Gen2 (8b/10b)
// PCIe data scrambler.  Polynomial x^16+x^5+x^4+x^3+1, seed 16'hFFFF.
// ---------------------------------------------------------------------------
package gen12_scrambler_pkg;

    localparam logic [7:0]  K_COM     = 8'hBC;
    localparam logic [7:0]  K_SKP     = 8'h1C;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [15:0] LFSR_TAPS = 16'h0039;

    // Advance the LFSR through one byte, data LSB first.
    // Returns {next_lfsr[15:0], scrambled_byte[7:0]}.
    function automatic logic [23:0] lfsr_step8(input logic [15:0] lfsr,
                                               input logic [7:0]  data);
        logic [15:0] l;
        logic [7:0]  o;
        l = lfsr;
        o = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            o[i] = data[i] ^ l[15];
            l    = {l[14:0], 1'b0} ^ (l[15] ? LFSR_TAPS : 16'h0000);
        end
        return {l, o};
    endfunction

endpackage

// File: rtl/gen12_lane_scrambler.sv
// ---------------------------------------------------------------------------
// gen12_lane_scrambler
// One lane of the scrambler: a combinational BYTES_PER_LANE-deep byte chain
// and the lane's 16-bit LFSR register, loaded on each accepted beat.
// Optional macro SCRAMBLER_LFSR_OBS_EN exposes the LFSR register as lfsr_o.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   load_i              beat accepted: LFSR takes the end-of-chain value
//   scramble_enable_i   0 = data bytes pass raw (LFSR still advances)
//   len_i               valid bytes minus 1 (clamped to BYTES_PER_LANE-1)
//   data_i/datak_i/ts_i lane symbols, byte 0 earliest
//   data_o              combinational scrambled bytes (0 beyond len)
//   lfsr_o              registered LFSR (only with SCRAMBLER_LFSR_OBS_EN)
// ---------------------------------------------------------------------------
module gen12_lane_scrambler
    import gen12_scrambler_pkg::*;
#(
    parameter int unsigned BYTES_PER_LANE = 4,
    parameter int unsigned LEN_W          = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load_i,
    input  logic                        scramble_enable_i,
    input  logic [LEN_W-1:0]            len_i,
    input  logic [BYTES_PER_LANE*8-1:0] data_i,
    input  logic [BYTES_PER_LANE-1:0]   datak_i,
    input  logic [BYTES_PER_LANE-1:0]   ts_i,
`ifdef SCRAMBLER_LFSR_OBS_EN
    output logic [15:0]                 lfsr_o,
`endif
    output logic [BYTES_PER_LANE*8-1:0] data_o
);

    localparam int unsigned LAST = BYTES_PER_LANE - 1;

    logic [15:0]  r_lfsr;
    logic [15:0]  w_lfsr_next;
    logic [23:0]  w_step;
    logic [7:0]   w_byte;
    int unsigned  w_len_lim;

    always_comb begin
        w_len_lim = 32'(len_i);
        if (w_len_lim > LAST)
            w_len_lim = LAST;
    end

    // The chain value after byte b feeds byte b+1; bytes past len_i are
    // zeroed and leave the chain untouched.
    always_comb begin
        w_lfsr_next = r_lfsr;
        data_o      = '0;
        w_step      = '0;
        w_byte      = '0;
        for (int unsigned b = 0; b < BYTES_PER_LANE; b++) begin
            if (b <= w_len_lim) begin
                w_byte = data_i[b*8 +: 8];
                w_step = lfsr_step8(w_lfsr_next, w_byte);
                if (datak_i[b] && w_byte == K_COM) begin
                    data_o[b*8 +: 8] = w_byte;
                    w_lfsr_next      = LFSR_SEED;
                end else if (datak_i[b] && w_byte == K_SKP) begin
                    data_o[b*8 +: 8] = w_byte;
                end else if (datak_i[b] || ts_i[b]) begin
                    data_o[b*8 +: 8] = w_byte;
                    w_lfsr_next      = w_step[23:8];
                end else begin
                    data_o[b*8 +: 8] = scramble_enable_i ? w_step[7:0] : w_byte;
                    w_lfsr_next      = w_step[23:8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_lfsr <= LFSR_SEED;
        else if (load_i)
            r_lfsr <= w_lfsr_next;
    end

`ifdef SCRAMBLER_LFSR_OBS_EN
    assign lfsr_o = r_lfsr;
`endif

endmodule

// File: rtl/gen12_multilane_scrambler.sv
// ---------------------------------------------------------------------------
// gen12_multilane_scrambler
// Gen1/Gen2 PCIe data scrambler for NUM_LANES lanes, BYTES_PER_LANE symbols
// per lane per beat, between the TX data mux and the 8b/10b encoders.
// Valid/ready stream with one registered output stage (latency 1).
// Optional macro SCRAMBLER_LFSR_OBS_EN adds lfsr_state_o (lane l at l*16).
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   in_valid_i / in_ready_o   input handshake
//   in_data_i/datak_i/ts_i    lane l byte b at (l*BYTES_PER_LANE+b)
//   in_len_i                  valid bytes per lane minus 1, all lanes
//   scramble_enable_i         0 = bypass scrambling
//   out_valid_o / out_ready_i output handshake
//   out_data_o/datak_o/len_o  registered beat
//   lfsr_state_o              per-lane LFSR (SCRAMBLER_LFSR_OBS_EN only)
// ---------------------------------------------------------------------------
module gen12_multilane_scrambler
    import gen12_scrambler_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned BYTES_PER_LANE = 4,
    parameter int unsigned LEN_W          = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [NUM_LANES*BYTES_PER_LANE*8-1:0] in_data_i,
    input  logic [NUM_LANES*BYTES_PER_LANE-1:0]   in_datak_i,
    input  logic [NUM_LANES*BYTES_PER_LANE-1:0]   in_ts_i,
    input  logic [LEN_W-1:0]                      in_len_i,
    input  logic                                  scramble_enable_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [NUM_LANES*BYTES_PER_LANE*8-1:0] out_data_o,
    output logic [NUM_LANES*BYTES_PER_LANE-1:0]   out_datak_o,
`ifdef SCRAMBLER_LFSR_OBS_EN
    output logic [NUM_LANES*16-1:0]               lfsr_state_o,
`endif
    output logic [LEN_W-1:0]                      out_len_o
);

    localparam int unsigned LB = BYTES_PER_LANE;

    logic                             w_accept;
    logic [NUM_LANES*LB*8-1:0]        w_lane_data;
    logic                             r_out_valid;
    logic [NUM_LANES*LB*8-1:0]        r_out_data;
    logic [NUM_LANES*LB-1:0]          r_out_datak;
    logic [LEN_W-1:0]                 r_out_len;

    assign in_ready_o = !r_out_valid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        gen12_lane_scrambler #(
            .BYTES_PER_LANE (BYTES_PER_LANE),
            .LEN_W          (LEN_W)
        ) u_lane (
            .clk_i             (clk_i),
            .rst_i             (rst_i),
            .load_i            (w_accept),
            .scramble_enable_i (scramble_enable_i),
            .len_i             (in_len_i),
            .data_i            (in_data_i[l*LB*8 +: LB*8]),
            .datak_i           (in_datak_i[l*LB +: LB]),
            .ts_i              (in_ts_i[l*LB +: LB]),
`ifdef SCRAMBLER_LFSR_OBS_EN
            .lfsr_o            (lfsr_state_o[l*16 +: 16]),
`endif
            .data_o            (w_lane_data[l*LB*8 +: LB*8])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_datak <= '0;
            r_out_len   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_lane_data;
            r_out_datak <= in_datak_i;
            r_out_len   <= in_len_i;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_datak_o = r_out_datak;
    assign out_len_o   = r_out_len;

endmodule

// File: tb/tb_gen12_multilane_scrambler.sv
// Directed bench for gen12_multilane_scrambler (4 lanes x 4 bytes).
// Expected bytes are the known Gen1/Gen2 keystream after a COM for zero data:
// FF 17 C0 14 B2 E7 02 ...
module tb_gen12_multilane_scrambler;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [127:0]   in_data_i = '0;
    logic [15:0]    in_datak_i = '0;
    logic [15:0]    in_ts_i = '0;
    logic [1:0]     in_len_i = '0;
    logic           scramble_enable_i = 1'b1;
    logic           out_valid_o;
    logic           out_ready_i = 1'b1;
    logic [127:0]   out_data_o;
    logic [15:0]    out_datak_o;
    logic [1:0]     out_len_o;
`ifdef SCRAMBLER_LFSR_OBS_EN
    logic [63:0]    lfsr_state_o;
`endif

    gen12_multilane_scrambler #(
        .NUM_LANES      (4),
        .BYTES_PER_LANE (4),
        .LEN_W          (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .in_data_i         (in_data_i),
        .in_datak_i        (in_datak_i),
        .in_ts_i           (in_ts_i),
        .in_len_i          (in_len_i),
        .scramble_enable_i (scramble_enable_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_data_o        (out_data_o),
        .out_datak_o       (out_datak_o),
`ifdef SCRAMBLER_LFSR_OBS_EN
        .lfsr_state_o      (lfsr_state_o),
`endif
        .out_len_o         (out_len_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0][31:0] din;
        logic [3:0][3:0]  dk;
        logic [3:0][3:0]  ts;
        logic [1:0]       len;
        logic             en;
        logic [3:0][31:0] exp;
    } vec_t;

    localparam int NV = 17;
    vec_t vt[NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] rep(input logic [31:0] w);
        return {w, w, w, w};
    endfunction

    function automatic vec_t mk(input logic [3:0][31:0] din, input logic [3:0][3:0] dk,
                                input logic [3:0][3:0] ts, input logic [1:0] len,
                                input logic en, input logic [3:0][31:0] exp);
        vec_t v;
        v.din = din; v.dk = dk; v.ts = ts; v.len = len; v.en = en; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_data_i         = v.din;
        in_datak_i        = v.dk;
        in_ts_i           = v.ts;
        in_len_i          = v.len;
        scramble_enable_i = v.en;
        in_valid_i        = 1'b1;
    endtask

    logic [3:0][3:0] k0;
    vec_t stall_a, stall_b;

    initial begin
        k0 = {4'b0001, 4'b0001, 4'b0001, 4'b0001};
        // COM + zeros: keystream FF 17 C0 in bytes 1-3
        vt[0]  = mk(rep(32'h000000BC), k0, '0, 2'd3, 1'b1, rep(32'hC017FFBC));
        vt[1]  = mk('0, '0, '0, 2'd3, 1'b1, rep(32'h02E7B214));
        // lane 0 byte 1 is SKP: lane 0 lags by one byte
        vt[2]  = mk({32'h000000BC, 32'h000000BC, 32'h000000BC, 32'h00001CBC},
                    {4'b0001, 4'b0001, 4'b0001, 4'b0011}, '0, 2'd3, 1'b1,
                    {32'hC017FFBC, 32'hC017FFBC, 32'hC017FFBC, 32'h17FF1CBC});
        vt[3]  = mk('0, '0, '0, 2'd3, 1'b1,
                    {32'h02E7B214, 32'h02E7B214, 32'h02E7B214, 32'hE7B214C0});
        // len=0 beats: bytes 1-3 ignored and zeroed
        vt[4]  = mk(rep(32'h000000BC), k0, '0, 2'd0, 1'b1, rep(32'h000000BC));
        vt[5]  = mk(rep(32'hAAAAAA00), '0, '0, 2'd0, 1'b1, rep(32'h000000FF));
        vt[6]  = mk(rep(32'hAAAAAA00), '0, '0, 2'd0, 1'b1, rep(32'h00000017));
        vt[7]  = mk(rep(32'hAAAAAA00), '0, '0, 2'd0, 1'b1, rep(32'h000000C0));
        vt[8]  = mk(rep(32'hAAAAAA00), '0, '0, 2'd0, 1'b1, rep(32'h00000014));
        vt[9]  = mk(rep(32'h000000BC), k0, '0, 2'd0, 1'b1, rep(32'h000000BC));
        vt[10] = mk('0, '0, '0, 2'd3, 1'b1, rep(32'h14C017FF));
        // bypass, TS and non-COM K still advance the LFSR
        vt[11] = mk(rep(32'h000000BC), k0, '0, 2'd0, 1'b1, rep(32'h000000BC));
        vt[12] = mk(rep(32'h00000033), '0, '0, 2'd0, 1'b0, rep(32'h00000033));
        vt[13] = mk({32'h00004A4A, 32'h00004A4A, 32'h00004AF7, 32'h00004A4A},
                    {4'b0000, 4'b0000, 4'b0001, 4'b0000},
                    {4'b0011, 4'b0011, 4'b0010, 4'b0011}, 2'd1, 1'b1,
                    {32'h00004A4A, 32'h00004A4A, 32'h00004AF7, 32'h00004A4A});
        vt[14] = mk('0, '0, '0, 2'd2, 1'b1, rep(32'h00E7B214));
        // two COMs in one beat: the later one governs
        vt[15] = mk(rep(32'h00BC00BC), {4'b0101, 4'b0101, 4'b0101, 4'b0101}, '0,
                    2'd3, 1'b1, rep(32'hFFBCFFBC));
        vt[16] = mk('0, '0, '0, 2'd0, 1'b1, rep(32'h00000017));

        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_valid", {127'd0, out_valid_o}, 128'd0);
        check("reset_data", out_data_o, 128'd0);
        check("reset_datak_len", {110'd0, out_datak_o, out_len_o}, 128'd0);
        check("reset_ready", {127'd0, in_ready_o}, 128'd1);
`ifdef SCRAMBLER_LFSR_OBS_EN
        check("reset_lfsr", {64'd0, lfsr_state_o}, {64'd0, {4{16'hFFFF}}});
`endif
        rst_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d_valid", i), {127'd0, out_valid_o}, 128'd1);
            check($sformatf("vec%0d_data", i), out_data_o, vt[i].exp);
            check($sformatf("vec%0d_datak_len", i), {110'd0, out_datak_o, out_len_o},
                  {110'd0, vt[i].dk, vt[i].len});
`ifdef SCRAMBLER_LFSR_OBS_EN
            if (i == 1)
                check("vec1_lfsr_lanes_equal", {64'd0, lfsr_state_o},
                      {64'd0, {4{lfsr_state_o[15:0]}}});
`endif
        end

        // backpressure: beat B held off for 3 cycles, then continues seamlessly
        stall_a = mk(rep(32'h000000BC), k0, '0, 2'd3, 1'b1, rep(32'hC017FFBC));
        stall_b = mk('0, '0, '0, 2'd3, 1'b1, rep(32'h02E7B214));
        drive(stall_a);
        @(posedge clk_i);
        #1;
        check("stall_a_data", out_data_o, stall_a.exp);
        drive(stall_b);
        out_ready_i = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall%0d_ready", c), {127'd0, in_ready_o}, 128'd0);
            @(posedge clk_i);
            #1;
            check($sformatf("stall%0d_hold", c), out_data_o, stall_a.exp);
            check($sformatf("stall%0d_valid", c), {127'd0, out_valid_o}, 128'd1);
        end
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("stall_b_data", out_data_o, stall_b.exp);
        in_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("drain_valid", {127'd0, out_valid_o}, 128'd0);

        // reset while a beat is held at the output: beat dropped, LFSRs reseeded
        drive(stall_b);
        out_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("pre_reset_valid", {127'd0, out_valid_o}, 128'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("midreset_valid", {127'd0, out_valid_o}, 128'd0);
        check("midreset_data", out_data_o, 128'd0);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_reset_seed", out_data_o, rep(32'h14C017FF));
        in_valid_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
